// File: rtl/tick_pwm.sv
// Tick-stepped PWM generator with a valid/ready config port. New period/duty
// values only take effect at a period boundary, and disabling finishes the current period.
module tick_pwm #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_i,
  input  logic             en_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [WIDTH-1:0] period_i,
  input  logic [WIDTH-1:0] duty_i,
  output logic             pwm_o,
  output logic             wrap_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] per_s_q, per_s_d;
  logic [WIDTH-1:0] duty_s_q, duty_s_d;
  logic             pend_q, pend_d;
  logic             wrap_q, wrap_d;

  logic active;
  logic wrap_ev;
  logic hs;

  assign active  = (state_q != StIdle);
  assign wrap_ev = active & tick_i & (cnt_q == per_q);
  assign hs      = cfg_valid_i & ~pend_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    per_d    = per_q;
    duty_d   = duty_q;
    per_s_d  = per_s_q;
    duty_s_d = duty_s_q;
    pend_d   = pend_q;
    wrap_d   = wrap_ev;

    if (active && tick_i) begin
      cnt_d = wrap_ev ? '0 : cnt_q + WIDTH'(1);
    end

    unique case (state_q)
      StIdle: begin
        // The tick seen in the start clock is not counted.
        if (en_i) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (!en_i) state_d = wrap_ev ? StIdle : StStop;
      end
      StStop: begin
        if (en_i)         state_d = StRun;
        else if (wrap_ev) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StIdle) cnt_d = '0;

    if (wrap_ev && pend_q) begin
      per_d  = per_s_q;
      duty_d = duty_s_q;
      pend_d = 1'b0;
    end

    // Accepting while idle or right at a boundary can go straight to the active set.
    if (hs) begin
      if (!active || wrap_ev) begin
        per_d  = period_i;
        duty_d = duty_i;
      end else begin
        per_s_d  = period_i;
        duty_s_d = duty_i;
        pend_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      per_q    <= '0;
      duty_q   <= '0;
      per_s_q  <= '0;
      duty_s_q <= '0;
      pend_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      duty_q   <= duty_d;
      per_s_q  <= per_s_d;
      duty_s_q <= duty_s_d;
      pend_q   <= pend_d;
      wrap_q   <= wrap_d;
    end
  end

  assign pwm_o       = active & (cnt_q < duty_q);
  assign wrap_o      = wrap_q;
  assign busy_o      = active;
  assign cfg_ready_o = ~pend_q;

endmodule

// File: tb/tb_tick_pwm.sv
// Bench for tick_pwm: directed stimulus queues the expected {pwm,wrap,busy,ready}
// for the clock after each tick; a monitor pops and compares on the following negedge.
module tb_tick_pwm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick_i = 1'b0;
  logic       en_i = 1'b0;
  logic       cfg_valid_i = 1'b0;
  logic [7:0] period_i = 8'd0;
  logic [7:0] duty_i = 8'd0;
  logic       cfg_ready_o;
  logic       pwm_o;
  logic       wrap_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;
  int n_tick = 0;
  logic [3:0] exp_q[$];

  tick_pwm #(.WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .tick_i      (tick_i),
    .en_i        (en_i),
    .cfg_valid_i (cfg_valid_i),
    .cfg_ready_o (cfg_ready_o),
    .period_i    (period_i),
    .duty_i      (duty_i),
    .pwm_o       (pwm_o),
    .wrap_o      (wrap_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b (pwm,wrap,busy,ready)", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {pwm_o, wrap_o, busy_o, cfg_ready_o};
  endfunction

  // One clock: inputs set now, sampled by the next posedge; returns 1 time unit after it.
  task automatic drive(input logic en, input logic tk, input logic cv,
                       input logic [7:0] p, input logic [7:0] d, input logic [3:0] e);
    en_i = en; tick_i = tk; cfg_valid_i = cv; period_i = p; duty_i = d;
    if (tk) exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic tk(input logic en, input logic [3:0] e);
    drive(en, 1'b1, 1'b0, 8'd0, 8'd0, e);
    drive(en, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
    drive(en, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
  endtask

  task automatic tkc(input logic en, input logic [7:0] p, input logic [7:0] d,
                     input logic [3:0] e);
    drive(en, 1'b1, 1'b1, p, d, e);
    drive(en, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
    drive(en, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
  endtask

  // Monitor: a tick sampled at a posedge is checked at the following negedge.
  initial begin
    bit t;
    logic [3:0] e;
    forever begin
      @(posedge clk);
      t = tick_i;
      @(negedge clk);
      if (t) begin
        n_tick++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tick%0d: got tick with no expectation queued", n_tick);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("tick%0d", n_tick), outs(), e);
        end
      end else begin
        chk("wrap_without_tick", {3'b000, wrap_o}, 4'b0000);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", outs(), 4'b0001);
    reset = 1'b0;

    // Config while idle goes straight to active regs.
    drive(1'b0, 1'b0, 1'b1, 8'd3, 8'd2, 4'd0);
    chk("idle_cfg", outs(), 4'b0001);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
    chk("start", outs(), 4'b1011);

    // per=3 duty=2: high at cnt 0,1.
    tk(1'b1, 4'b1011); tk(1'b1, 4'b0011); tk(1'b1, 4'b0011); tk(1'b1, 4'b1111);
    tk(1'b1, 4'b1011); tk(1'b1, 4'b0011); tk(1'b1, 4'b0011);
    // Handshake on the wrap tick: applies from cnt=0, ready stays 1.
    tkc(1'b1, 8'd3, 8'd1, 4'b1111);
    tk(1'b1, 4'b0011); tk(1'b1, 4'b0011); tk(1'b1, 4'b0011); tk(1'b1, 4'b1111);

    // Mid-period offer goes to shadow until the wrap.
    tk(1'b1, 4'b0011);
    drive(1'b1, 1'b0, 1'b1, 8'd1, 8'd1, 4'd0);
    chk("pending", outs(), 4'b0010);
    tk(1'b1, 4'b0010); tk(1'b1, 4'b0010); tk(1'b1, 4'b1111);
    tk(1'b1, 4'b0011); tk(1'b1, 4'b1111); tk(1'b1, 4'b0011); tk(1'b1, 4'b1111);

    // duty=0, duty>per, per=0.
    tk(1'b1, 4'b0011);
    tkc(1'b1, 8'd3, 8'd0, 4'b0111);
    tk(1'b1, 4'b0011); tk(1'b1, 4'b0011); tk(1'b1, 4'b0011);
    tkc(1'b1, 8'd3, 8'd9, 4'b1111);
    tk(1'b1, 4'b1011); tk(1'b1, 4'b1011); tk(1'b1, 4'b1011);
    tkc(1'b1, 8'd0, 8'd1, 4'b1111);
    tk(1'b1, 4'b1111); tk(1'b1, 4'b1111); tk(1'b1, 4'b1111);

    // Disable after tick 1: period completes, then idle.
    tkc(1'b1, 8'd3, 8'd2, 4'b1111);
    tk(1'b1, 4'b1011); tk(1'b0, 4'b0011); tk(1'b0, 4'b0011); tk(1'b0, 4'b0101);
    chk("idle_after_stop", outs(), 4'b0001);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
    chk("restart", outs(), 4'b1011);
    tk(1'b1, 4'b1011); tk(1'b0, 4'b0011);
    chk("stop_busy", outs(), 4'b0011);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
    tk(1'b1, 4'b0011); tk(1'b1, 4'b1111); tk(1'b1, 4'b1011);

    // Reset mid-period with a pending config.
    drive(1'b1, 1'b0, 1'b1, 8'd1, 8'd1, 4'd0);
    chk("pending2", outs(), 4'b1010);
    tk(1'b1, 4'b0010);
    #2 reset = 1'b1;
    #1 chk("reset_mid", outs(), 4'b0001);
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
    #2 reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
    chk("post_reset", outs(), 4'b0011);
    tk(1'b1, 4'b0111); tk(1'b1, 4'b0111); tk(1'b1, 4'b0111);

    repeat (3) drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked expectations want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
